rx_data_controller: RTL and testbench

RX_DATA_CONTROLLER -- requirements
Module: rx_data_controller

---
 rtl/aurora_pkg.sv | 19 +
 rtl/rx_data_controller.sv | 90 +++++++++
 tb/tb_rx_data_controller.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/aurora_pkg.sv
// Shared Aurora RX types: payload width, received symbol kinds, RX FSM states.
// Consumed by rx_data_controller.
package aurora_pkg;

  localparam int AXI_DATA_SIZE = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCP  = 2'd1,
    DATA = 2'd2,
    ECP  = 2'd3
  } ordered_sets_e;

  typedef enum logic {
    WAIT_S  = 1'b0,
    FRAME_S = 1'b1
  } rx_state_e;

endpackage

// File: rtl/rx_data_controller.sv
// Aurora RX framer: SCP/DATA/ECP symbols to an AXI-stream style word output.
// Optional RX_FRAME_CNT_EN adds a 16-bit completed-frame counter port.
module rx_data_controller
  import aurora_pkg::*;
(
  input  logic                     clk_data,
  input  logic                     rst_n,
  input  ordered_sets_e            ordered_sets,
  input  logic [AXI_DATA_SIZE-1:0] data_in,
  output logic                     axi_valid,
  output logic                     axi_last,
  output logic [AXI_DATA_SIZE-1:0] axi_data,
  output logic                     frame_error
`ifdef RX_FRAME_CNT_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  rx_state_e                r_state;
  logic                     r_hold_valid;
  logic [AXI_DATA_SIZE-1:0] r_hold;

  // One word is held back until the next symbol tells us if it is last.
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= WAIT_S;
      r_hold_valid <= 1'b0;
      r_hold       <= '0;
      axi_valid    <= 1'b0;
      axi_last     <= 1'b0;
      axi_data     <= '0;
      frame_error  <= 1'b0;
    end else begin
      axi_valid   <= 1'b0;
      axi_last    <= 1'b0;
      axi_data    <= '0;
      frame_error <= 1'b0;
      unique case (r_state)
        WAIT_S: begin
          unique case (ordered_sets)
            SCP: begin
              r_state      <= FRAME_S;
              r_hold_valid <= 1'b0;
            end
            DATA, ECP: frame_error <= 1'b1;
            IDLE: ;
          endcase
        end
        FRAME_S: begin
          unique case (ordered_sets)
            DATA: begin
              if (r_hold_valid) begin
                axi_valid <= 1'b1;
                axi_data  <= r_hold;
              end
              r_hold       <= data_in;
              r_hold_valid <= 1'b1;
            end
            ECP: begin
              if (r_hold_valid) begin
                axi_valid <= 1'b1;
                axi_last  <= 1'b1;
                axi_data  <= r_hold;
              end
              r_hold_valid <= 1'b0;
              r_state      <= WAIT_S;
            end
            SCP: begin
              frame_error  <= 1'b1;
              r_hold_valid <= 1'b0;
            end
            IDLE: ;
          endcase
        end
      endcase
    end
  end

`ifdef RX_FRAME_CNT_EN
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= '0;
    end else if (axi_valid && axi_last) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rx_data_controller.sv
// Scoreboard bench for rx_data_controller.
// Define RX_FRAME_CNT_EN to also exercise frame_count.
module tb_rx_data_controller;
  import aurora_pkg::*;

  logic                     clk_data = 1'b0;
  logic                     rst_n = 1'b0;
  ordered_sets_e            ordered_sets = IDLE;
  logic [AXI_DATA_SIZE-1:0] data_in = '0;
  logic                     axi_valid;
  logic                     axi_last;
  logic [AXI_DATA_SIZE-1:0] axi_data;
  logic                     frame_error;
`ifdef RX_FRAME_CNT_EN
  logic [15:0]              frame_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_fe = 0;
  logic [AXI_DATA_SIZE:0] sb_q[$];

  rx_data_controller dut (
    .clk_data    (clk_data),
    .rst_n       (rst_n),
    .ordered_sets(ordered_sets),
    .data_in     (data_in),
    .axi_valid   (axi_valid),
    .axi_last    (axi_last),
    .axi_data    (axi_data),
    .frame_error (frame_error)
`ifdef RX_FRAME_CNT_EN
    ,
    .frame_count (frame_count)
`endif
  );

  always #5 clk_data = ~clk_data;

  always @(negedge clk_data) begin
    if (rst_n) begin
      if (frame_error) n_fe++;
      if (axi_valid) begin
        n_valid++;
        n_cmp++;
        if (sb_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_word: got data=%h last=%b, required no output",
                   axi_data, axi_last);
        end else begin
          logic [AXI_DATA_SIZE:0] e;
          e = sb_q.pop_front();
          if ({axi_last, axi_data} !== e) begin
            n_err++;
            $display("FAIL word: got last=%b data=%h, required last=%b data=%h",
                     axi_last, axi_data, e[AXI_DATA_SIZE], e[AXI_DATA_SIZE-1:0]);
          end
        end
      end else begin
        n_cmp++;
        if (axi_last !== 1'b0 || axi_data !== '0) begin
          n_err++;
          $display("FAIL idle_outputs: got last=%b data=%h, required 0/0",
                   axi_last, axi_data);
        end
      end
    end
  end

  task automatic sym(input ordered_sets_e s, input logic [AXI_DATA_SIZE-1:0] d);
    ordered_sets = s;
    data_in = d;
    @(posedge clk_data);
    #1;
  endtask

  task automatic idle(input int n);
    ordered_sets = IDLE;
    data_in = '0;
    repeat (n) @(posedge clk_data);
    #1;
  endtask

  task automatic expect_word(input logic [AXI_DATA_SIZE-1:0] d, input logic l);
    sb_q.push_back({l, d});
  endtask

  task automatic check_end(input string name, input int dv, input int dfe,
                           input int v0, input int fe0);
    idle(3);
    n_cmp++;
    if (sb_q.size() != 0 || (n_valid - v0) != dv || (n_fe - fe0) != dfe) begin
      n_err++;
      $display("FAIL %s: got pending=%0d words=%0d errors=%0d, required 0/%0d/%0d",
               name, sb_q.size(), n_valid - v0, n_fe - fe0, dv, dfe);
      sb_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    @(negedge clk_data);
    n_cmp++;
    if (axi_valid !== 1'b0 || axi_last !== 1'b0 || axi_data !== '0 ||
        frame_error !== 1'b0) begin
      n_err++;
      $display("FAIL %s: got v=%b l=%b d=%h fe=%b, required all zero",
               name, axi_valid, axi_last, axi_data, frame_error);
    end
`ifdef RX_FRAME_CNT_EN
    n_cmp++;
    if (frame_count !== 16'd0) begin
      n_err++;
      $display("FAIL %s_count: got %h, required 0000", name, frame_count);
    end
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(2);
    check_reset_outputs("reset");
    @(posedge clk_data);
    #1;
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_single();
    int v0 = n_valid;
    int fe0 = n_fe;
    expect_word(64'hDEADB00DDEADB00D, 1'b1);
    sym(SCP, '0);
    sym(DATA, 64'hDEADB00DDEADB00D);
    sym(ECP, '0);
    check_end("single", 1, 0, v0, fe0);
  endtask

  task automatic test_gaps();
    int v0 = n_valid;
    int fe0 = n_fe;
    for (int i = 1; i <= 7; i++) expect_word(64'(i), i == 7);
    sym(SCP, '0);
    for (int i = 1; i <= 7; i++) begin
      sym(DATA, 64'(i));
      if (i >= 2 && i <= 4) idle(i);
    end
    sym(ECP, '0);
    check_end("gaps", 7, 0, v0, fe0);
  endtask

  task automatic test_back_to_back();
    int v0 = n_valid;
    int fe0 = n_fe;
    expect_word(64'hA5, 1'b1);
    sym(SCP, '0);
    sym(ECP, '0);
    sym(SCP, '0);
    sym(DATA, 64'hA5);
    sym(ECP, '0);
    check_end("back_to_back", 1, 0, v0, fe0);
  endtask

  task automatic test_errors();
    int v0 = n_valid;
    int fe0 = n_fe;
    sym(DATA, 64'h99);
    idle(1);
    sym(ECP, '0);
    check_end("outside_frame", 0, 2, v0, fe0);
    v0 = n_valid;
    fe0 = n_fe;
    expect_word(64'h22, 1'b1);
    sym(SCP, '0);
    sym(DATA, 64'h11);
    sym(SCP, '0);
    sym(DATA, 64'h22);
    sym(ECP, '0);
    check_end("nested_scp", 1, 1, v0, fe0);
  endtask

  task automatic test_reset_midframe();
    int v0 = n_valid;
    int fe0 = n_fe;
    sym(SCP, '0);
    sym(DATA, 64'h33);
    rst_n = 1'b0;
    ordered_sets = IDLE;
    check_reset_outputs("midframe_reset_a");
    check_reset_outputs("midframe_reset_b");
    @(posedge clk_data);
    #1;
    rst_n = 1'b1;
    sym(ECP, '0);
    check_end("midframe_reset", 0, 1, v0, fe0);
  endtask

`ifdef RX_FRAME_CNT_EN
  task automatic frame(input logic [AXI_DATA_SIZE-1:0] d);
    expect_word(d, 1'b1);
    sym(SCP, '0);
    sym(DATA, d);
    sym(ECP, '0);
  endtask

  task automatic test_frame_count();
    rst_n = 1'b0;
    idle(1);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) frame(64'(i + 5));
    idle(3);
    n_cmp++;
    if (frame_count !== 16'd3) begin
      n_err++;
      $display("FAIL count3: got %0d, required 3", frame_count);
    end
    for (int i = 3; i < 65535; i++) frame(64'(i));
    idle(3);
    n_cmp++;
    if (frame_count !== 16'hFFFF) begin
      n_err++;
      $display("FAIL count_max: got %h, required ffff", frame_count);
    end
    frame(64'h77);
    idle(3);
    n_cmp++;
    if (frame_count !== 16'h0000) begin
      n_err++;
      $display("FAIL count_wrap: got %h, required 0000", frame_count);
    end
    sb_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gaps();
    test_back_to_back();
    test_errors();
    test_reset_midframe();
`ifdef RX_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
